ctrl_xfer_unit: RTL and testbench

Parametrised control-transfer unit for the RV32/RV64 execute stage. It resolves JAL, JALR and conditional branches and registers its results for one cycle. It also maintains a circular return-address stack (RAS) that the fetch stage reads for return prediction. Its outputs feed the register-file write port and the fetch redirect path.

---
 rtl/ctrl_xfer_unit_if.sv | 41 ++++
 rtl/ctrl_xfer_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_ctrl_xfer_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_xfer_unit_if.sv
// ctrl_xfer_unit_if: execute-stage control-transfer bundle.
// Master drives the op, slave returns registered results and RAS state.
interface ctrl_xfer_unit_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            flush;
   logic [1:0]      op;
   logic [2:0]      funct3;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_idx;
   logic [4:0]      rs1_idx;
   logic            out_valid;
   logic            rd_we;
   logic [XLEN-1:0] rd_val;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            misalign_exc;
   logic            ras_hit;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;

   modport master (
      output in_valid, flush, op, funct3, pc, imm,
      output rs1_val, rs2_val, rd_idx, rs1_idx,
      input  out_valid, rd_we, rd_val, redirect,
      input  redirect_pc, misalign_exc, ras_hit,
      input  ras_top, ras_empty
   );

   modport slave (
      input  in_valid, flush, op, funct3, pc, imm,
      input  rs1_val, rs2_val, rd_idx, rs1_idx,
      output out_valid, rd_we, rd_val, redirect,
      output redirect_pc, misalign_exc, ras_hit,
      output ras_top, ras_empty
   );
endinterface

// File: rtl/ctrl_xfer_unit.sv
// ctrl_xfer_unit: resolves JAL/JALR/branches with one-cycle registered
// results and keeps a circular return-address stack for fetch.
module ctrl_xfer_unit #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 8
) (
   input logic             clk,
   input logic             rst,
   ctrl_xfer_unit_if.slave bus
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_JAL  = 2'b01,
      OP_JALR = 2'b10,
      OP_BR   = 2'b11
   } op_e;

   op_e             op;
   logic            accept;
   logic [XLEN-1:0] sum_pc;
   logic [XLEN-1:0] sum_rs1;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] link_addr;
   logic            taken;
   logic            jump;
   logic            exc;
   logic            ok;
   logic            rd_link;
   logic            rs1_link;

   logic            push_req;
   logic            pop_req;
   logic            ovw_req;

   logic [XLEN-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   logic [XLEN-1:0] top_val;
   logic            empty;

   logic            out_valid_q, out_valid_d;
   logic            rd_we_q, rd_we_d;
   logic [XLEN-1:0] rd_val_q, rd_val_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            misalign_q, misalign_d;
   logic            ras_hit_q, ras_hit_d;

   assign op        = op_e'(bus.op);
   assign accept    = bus.in_valid & ~bus.flush;
   assign link_addr = bus.pc + XLEN'(4);
   assign rd_link   = (bus.rd_idx == 5'd1) | (bus.rd_idx == 5'd5);
   assign rs1_link  = (bus.rs1_idx == 5'd1) | (bus.rs1_idx == 5'd5);
   assign top_val   = mem_q[top_q];
   assign empty     = (cnt_q == '0);

   // Target addresses; JALR clears bit 0 of the sum.
   always_comb begin
      sum_pc  = bus.pc + bus.imm;
      sum_rs1 = bus.rs1_val + bus.imm;
      tgt     = sum_pc;
      if (op == OP_JALR) begin
         tgt = sum_rs1 & {{(XLEN-1){1'b1}}, 1'b0};
      end
   end

   // Branch condition; reserved encodings never take.
   always_comb begin
      taken = 1'b0;
      case (bus.funct3)
         3'b000: taken = (bus.rs1_val == bus.rs2_val);
         3'b001: taken = (bus.rs1_val != bus.rs2_val);
         3'b100: taken = ($signed(bus.rs1_val) < $signed(bus.rs2_val));
         3'b101: taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
         3'b110: taken = (bus.rs1_val < bus.rs2_val);
         3'b111: taken = (bus.rs1_val >= bus.rs2_val);
         default: taken = 1'b0;
      endcase
   end

   // Redirect decision and alignment fault.
   always_comb begin
      jump = 1'b0;
      case (op)
         OP_JAL, OP_JALR: jump = 1'b1;
         OP_BR:           jump = taken;
         default:         jump = 1'b0;
      endcase
      exc = jump & (tgt[1:0] != 2'b00);
      ok  = accept & ~exc;
   end

   // Classify the stack action from link-register usage.
   always_comb begin
      push_req = 1'b0;
      pop_req  = 1'b0;
      ovw_req  = 1'b0;
      if (ok) begin
         case (op)
            OP_JAL: push_req = rd_link;
            OP_JALR: begin
               if (rd_link && rs1_link) begin
                  if (bus.rd_idx == bus.rs1_idx) push_req = 1'b1;
                  else                            ovw_req  = 1'b1;
               end else if (rd_link) begin
                  push_req = 1'b1;
               end else if (rs1_link) begin
                  pop_req = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Stack pointer/count update; overwrite on empty degrades to push.
   always_comb begin
      top_d     = top_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      wr_idx    = top_q;
      ras_hit_d = 1'b0;
      if ((pop_req | ovw_req) && !empty && (top_val == tgt)) begin
         ras_hit_d = 1'b1;
      end
      if (push_req || (ovw_req && empty)) begin
         top_d  = top_q + PW'(1);
         wr_idx = top_q + PW'(1);
         wr_en  = 1'b1;
         if (cnt_q != FULL) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (pop_req && !empty) begin
         top_d = top_q - PW'(1);
         cnt_d = cnt_q - CW'(1);
      end else if (ovw_req) begin
         wr_en = 1'b1;
      end
   end

   // Next values of the registered result bundle.
   always_comb begin
      out_valid_d   = 1'b0;
      rd_we_d       = 1'b0;
      rd_val_d      = '0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      misalign_d    = 1'b0;
      if (accept) begin
         out_valid_d = 1'b1;
         if (op == OP_JAL || op == OP_JALR) begin
            rd_val_d = link_addr;
         end
         if (jump) begin
            redirect_pc_d = tgt;
            if (exc) begin
               misalign_d = 1'b1;
            end else begin
               redirect_d = 1'b1;
               rd_we_d    = (op != OP_BR);
            end
         end
      end
   end

   // Result registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         rd_we_q       <= 1'b0;
         rd_val_q      <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         misalign_q    <= 1'b0;
         ras_hit_q     <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         rd_we_q       <= rd_we_d;
         rd_val_q      <= rd_val_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         misalign_q    <= misalign_d;
         ras_hit_q     <= ras_hit_d;
      end
   end

   // Stack pointer and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack storage; validity is tracked by cnt_q, so no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_idx] <= link_addr;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.rd_we        = rd_we_q;
   assign bus.rd_val       = rd_val_q;
   assign bus.redirect     = redirect_q;
   assign bus.redirect_pc  = redirect_pc_q;
   assign bus.misalign_exc = misalign_q;
   assign bus.ras_hit      = ras_hit_q;
   assign bus.ras_top      = empty ? '0 : top_val;
   assign bus.ras_empty    = empty;

endmodule

// File: tb/tb_ctrl_xfer_unit.sv
// tb_ctrl_xfer_unit: directed steps with a scoreboard fed by a
// behavioural model of the unit and a queue-based return stack.
module tb_ctrl_xfer_unit;

   localparam int D = 4;
   localparam logic [1:0] NONE = 2'd0;
   localparam logic [1:0] JAL  = 2'd1;
   localparam logic [1:0] JALR = 2'd2;
   localparam logic [1:0] BR   = 2'd3;

   typedef struct packed {
      logic        ov;
      logic        we;
      logic [31:0] rdv;
      logic        rdr;
      logic [31:0] rpc;
      logic        exc;
      logic        hit;
      logic [31:0] top;
      logic        emp;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb[$];
   logic [31:0] ras_m[$];

   ctrl_xfer_unit_if #(.XLEN(32)) bus ();

   ctrl_xfer_unit #(.XLEN(32), .RAS_DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mpush(input logic [31:0] v);
      ras_m.push_back(v);
      if (ras_m.size() > D) ras_m.delete(0);
   endtask

   task automatic step(input logic r, input logic v, input logic f,
                       input logic [1:0] o, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [4:0] rs1);
      exp_t e;
      exp_t g;
      logic [31:0] t;
      logic tk, jmp, lrd, lrs;
      rst = r;
      bus.in_valid = v;
      bus.flush = f;
      bus.op = o;
      bus.funct3 = f3;
      bus.pc = p;
      bus.imm = im;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_idx = rd;
      bus.rs1_idx = rs1;
      e = '0;
      if (r) begin
         ras_m.delete();
      end else if (v && !f) begin
         e.ov = 1'b1;
         t = (o == JALR) ? ((a + im) & 32'hFFFF_FFFE) : (p + im);
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
         endcase
         jmp = (o == JAL) || (o == JALR) || (o == BR && tk);
         if (o == JAL || o == JALR) e.rdv = p + 32'd4;
         if (jmp) begin
            e.rpc = t;
            if (t[1:0] != 2'b00) e.exc = 1'b1;
            else begin
               e.rdr = 1'b1;
               e.we = (o != BR);
            end
         end
         lrd = (rd == 5'd1) || (rd == 5'd5);
         lrs = (rs1 == 5'd1) || (rs1 == 5'd5);
         if (jmp && !e.exc) begin
            if (o == JAL && lrd) mpush(p + 32'd4);
            if (o == JALR) begin
               if (lrs && (!lrd || rd != rs1)) begin
                  if (ras_m.size() > 0) begin
                     if (ras_m[$] == t) e.hit = 1'b1;
                     ras_m.delete(ras_m.size() - 1);
                  end
                  if (lrd) mpush(p + 32'd4);
               end else if (lrd) begin
                  mpush(p + 32'd4);
               end
            end
         end
      end
      e.emp = (ras_m.size() == 0);
      e.top = e.emp ? 32'd0 : ras_m[$];
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, g.ov});
      chk("rd_we", {31'd0, bus.rd_we}, {31'd0, g.we});
      chk("rd_val", bus.rd_val, g.rdv);
      chk("redirect", {31'd0, bus.redirect}, {31'd0, g.rdr});
      chk("redirect_pc", bus.redirect_pc, g.rpc);
      chk("misalign", {31'd0, bus.misalign_exc}, {31'd0, g.exc});
      chk("ras_hit", {31'd0, bus.ras_hit}, {31'd0, g.hit});
      chk("ras_top", bus.ras_top, g.top);
      chk("ras_empty", {31'd0, bus.ras_empty}, {31'd0, g.emp});
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.op = NONE;
      bus.funct3 = 3'd0;
      bus.pc = '0;
      bus.imm = '0;
      bus.rs1_val = '0;
      bus.rs2_val = '0;
      bus.rd_idx = '0;
      bus.rs1_idx = '0;
      @(negedge clk);
      step(1, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, JAL, 0, 32'h40, 32'h8, 0, 0, 1, 0);
      chk("rst_empty", {31'd0, bus.ras_empty}, 32'd1);

      // call then return
      step(0, 1, 0, JAL, 0, 32'h100, 32'h40, 0, 0, 1, 0);
      chk("call_rdval", bus.rd_val, 32'h104);
      chk("call_rpc", bus.redirect_pc, 32'h140);
      chk("call_top", bus.ras_top, 32'h104);
      step(0, 1, 0, JALR, 0, 32'h140, 0, 32'h104, 0, 0, 1);
      chk("ret_rpc", bus.redirect_pc, 32'h104);
      chk("ret_hit", {31'd0, bus.ras_hit}, 32'd1);
      chk("ret_empty", {31'd0, bus.ras_empty}, 32'd1);

      // branches
      step(0, 1, 0, BR, 3'd4, 32'h200, 32'hFFFF_FFF8,
           32'hFFFF_FFFF, 32'd1, 0, 0);
      chk("blt_redir", {31'd0, bus.redirect}, 32'd1);
      chk("blt_rpc", bus.redirect_pc, 32'h1F8);
      step(0, 1, 0, BR, 3'd6, 32'h200, 32'hFFFF_FFF8,
           32'hFFFF_FFFF, 32'd1, 0, 0);
      chk("bltu_redir", {31'd0, bus.redirect}, 32'd0);
      step(0, 1, 0, BR, 3'd2, 32'h200, 32'hFFFF_FFF8,
           32'hFFFF_FFFF, 32'd1, 0, 0);
      chk("f3_010_redir", {31'd0, bus.redirect}, 32'd0);
      chk("f3_010_rpc", bus.redirect_pc, 32'd0);
      step(0, 1, 0, BR, 3'd3, 32'h200, 32'h10, 32'd1, 32'd1, 0, 0);
      step(0, 1, 0, BR, 3'd5, 32'h200, 32'h10,
           32'hFFFF_FFFF, 32'd1, 0, 0);
      step(0, 1, 0, BR, 3'd7, 32'h200, 32'h10,
           32'hFFFF_FFFF, 32'd1, 0, 0);
      step(0, 1, 0, BR, 3'd0, 32'h200, 32'h10, 32'd7, 32'd7, 1, 1);
      step(0, 1, 0, BR, 3'd1, 32'h200, 32'h10, 32'd7, 32'd7, 0, 0);
      step(0, 1, 0, BR, 3'd0, 32'h300, 32'h2, 32'd5, 32'd5, 0, 0);
      chk("br_misalign", {31'd0, bus.misalign_exc}, 32'd1);
      step(0, 1, 0, NONE, 0, 32'h400, 32'h4, 32'd3, 32'd3, 1, 1);
      chk("none_valid", {31'd0, bus.out_valid}, 32'd1);

      // overflow of a 4-entry stack
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0, JAL, 0, 32'(i * 16 - 4), 32'h100, 0, 0, 1, 0);
      end
      chk("ovf_top", bus.ras_top, 32'h50);
      for (int i = 5; i >= 2; i--) begin
         step(0, 1, 0, JALR, 0, 32'h600, 0, 32'(i * 16), 0, 0, 5);
         chk("ovf_pop_hit", {31'd0, bus.ras_hit}, 32'd1);
      end
      chk("ovf_drained", {31'd0, bus.ras_empty}, 32'd1);
      step(0, 1, 0, JALR, 0, 32'h600, 0, 32'h60, 0, 0, 5);
      chk("pop_empty_hit", {31'd0, bus.ras_hit}, 32'd0);
      chk("pop_empty_emp", {31'd0, bus.ras_empty}, 32'd1);

      // misaligned JALR leaves stack alone
      step(0, 1, 0, JAL, 0, 32'h7FC, 0, 0, 0, 5, 0);
      step(0, 1, 0, JALR, 0, 32'h700, 32'd1, 32'h1001, 0, 1, 2);
      chk("mis_exc", {31'd0, bus.misalign_exc}, 32'd1);
      chk("mis_redir", {31'd0, bus.redirect}, 32'd0);
      chk("mis_we", {31'd0, bus.rd_we}, 32'd0);
      chk("mis_rpc", bus.redirect_pc, 32'h1002);
      chk("mis_top", bus.ras_top, 32'h800);
      step(0, 1, 0, JALR, 0, 32'h700, 0, 32'h2001, 0, 0, 2);
      chk("align_exc", {31'd0, bus.misalign_exc}, 32'd0);
      chk("align_rpc", bus.redirect_pc, 32'h2000);

      // overwrite and rd==rs1 push
      step(0, 1, 0, JALR, 0, 32'h900, 0, 32'h800, 0, 1, 5);
      chk("ovw_hit", {31'd0, bus.ras_hit}, 32'd1);
      chk("ovw_top", bus.ras_top, 32'h904);
      step(0, 1, 0, JALR, 0, 32'hA00, 0, 32'h3000, 0, 5, 5);
      chk("same_push_top", bus.ras_top, 32'hA04);
      step(0, 1, 0, JALR, 0, 32'hB00, 0, 32'hA04, 0, 0, 1);
      step(0, 1, 0, JALR, 0, 32'hC00, 0, 32'h904, 0, 0, 1);
      step(0, 1, 0, JALR, 0, 32'hD00, 0, 32'h4000, 0, 5, 1);
      chk("ovw_empty_top", bus.ras_top, 32'hD04);

      // flush then reset mid-stream
      step(1, 0, 0, NONE, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, JAL, 0, 32'h100, 32'h40, 0, 0, 1, 0);
      chk("flush_ov", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_empty", {31'd0, bus.ras_empty}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, JAL, 0, 32'(32'h1000 + i * 16), 32'h8, 0, 0, 1, 0);
      end
      step(1, 1, 0, JAL, 0, 32'h2000, 32'h8, 0, 0, 1, 0);
      chk("rst_mid_empty", {31'd0, bus.ras_empty}, 32'd1);
      chk("rst_mid_ov", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_mid_rdval", bus.rd_val, 32'd0);
      step(0, 1, 0, JAL, 0, 32'h3000, 32'h8, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
